// File: rtl/guess_filter_pkg.sv
// Shared constants for the guess filter: letter codes, game status encodings,
// scan codes and the PS/2 prefix state type.
package guess_filter_pkg;

  localparam logic [4:0] LTR_ENTER = 5'd26;
  localparam logic [4:0] LTR_NONE  = 5'd31;

  localparam logic [1:0] GS_IDLE = 2'd0;
  localparam logic [1:0] GS_PLAY = 2'd1;
  localparam logic [1:0] GS_WON  = 2'd2;
  localparam logic [1:0] GS_LOST = 2'd3;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {PfxNorm, PfxExt, PfxBrk, PfxExtBrk} pfx_e;

endpackage

// File: rtl/scancode_to_letter.sv
// Combinational set-2 scan-code decoder: A..Z -> 0..25, Enter -> 26, else 31.
module scancode_to_letter
  import guess_filter_pkg::*;
(
  input  logic [7:0] code,
  output logic [4:0] letter
);

  always_comb begin
    letter = LTR_NONE;
    case (code)
      8'h1C: letter = 5'd0;
      8'h32: letter = 5'd1;
      8'h21: letter = 5'd2;
      8'h23: letter = 5'd3;
      8'h24: letter = 5'd4;
      8'h2B: letter = 5'd5;
      8'h34: letter = 5'd6;
      8'h33: letter = 5'd7;
      8'h43: letter = 5'd8;
      8'h3B: letter = 5'd9;
      8'h42: letter = 5'd10;
      8'h4B: letter = 5'd11;
      8'h3A: letter = 5'd12;
      8'h31: letter = 5'd13;
      8'h44: letter = 5'd14;
      8'h4D: letter = 5'd15;
      8'h15: letter = 5'd16;
      8'h2D: letter = 5'd17;
      8'h1B: letter = 5'd18;
      8'h2C: letter = 5'd19;
      8'h3C: letter = 5'd20;
      8'h2A: letter = 5'd21;
      8'h1D: letter = 5'd22;
      8'h22: letter = 5'd23;
      8'h35: letter = 5'd24;
      8'h1A: letter = 5'd25;
      SC_ENTER: letter = LTR_ENTER;
      default: letter = LTR_NONE;
    endcase
  end

endmodule

// File: rtl/guess_filter.sv
// PS/2 byte stream -> scored letter guesses and game status.
// Optional GUESS_FILTER_ABORT_EN: Esc during play forces LOST.
module guess_filter
  import guess_filter_pkg::*;
#(
  parameter int unsigned MAX_WRONG  = 6,
  parameter logic [7:0]  BREAK_CODE = 8'hF0,
  parameter logic [7:0]  EXT_CODE   = 8'hE0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic [25:0] mask,
  output logic        guess_valid,
  output logic [4:0]  guess_letter,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        repeat_pulse,
  output logic        start_game,
  output logic [25:0] guessed,
  output logic [3:0]  wrong_count,
  output logic [1:0]  game_status
);

  localparam logic [3:0] MaxWrong = 4'(MAX_WRONG);

  pfx_e        state_q;
  logic [7:0]  held_q;
  logic [4:0]  letter;
  logic        fresh, brk_ev, is_letter, already, in_mask;
  logic [25:0] ltr_bit, guessed_post;
  logic [3:0]  wrong_post;

  scancode_to_letter u_dec (
    .code   (key_code),
    .letter (letter)
  );

  always_comb begin
    // A fresh make is a non-prefix byte in NORM that is not the key already held down.
    fresh        = key_valid && (state_q == PfxNorm) && (key_code != EXT_CODE) &&
                   (key_code != BREAK_CODE) && (key_code != held_q);
    brk_ev       = key_valid && (state_q == PfxBrk);
    is_letter    = letter < LTR_ENTER;
    ltr_bit      = is_letter ? (26'd1 << letter) : 26'd0;
    already      = |(guessed & ltr_bit);
    in_mask      = |(mask & ltr_bit);
    guessed_post = guessed | ltr_bit;
    wrong_post   = wrong_count;
    if (!in_mask && (wrong_count < MaxWrong)) wrong_post = wrong_count + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= PfxNorm;
      held_q       <= 8'h00;
      guess_valid  <= 1'b0;
      guess_letter <= 5'd0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      start_game   <= 1'b0;
      guessed      <= 26'd0;
      wrong_count  <= 4'd0;
      game_status  <= GS_IDLE;
    end else begin
      guess_valid  <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      start_game   <= 1'b0;

      if (key_valid) begin
        case (state_q)
          PfxNorm: begin
            if (key_code == EXT_CODE)        state_q <= PfxExt;
            else if (key_code == BREAK_CODE) state_q <= PfxBrk;
          end
          PfxExt:  state_q <= (key_code == BREAK_CODE) ? PfxExtBrk : PfxNorm;
          default: state_q <= PfxNorm;
        endcase
      end

      if (brk_ev && (key_code == held_q)) held_q <= 8'h00;

      if (fresh) begin
        held_q <= key_code;
        if (is_letter && (game_status == GS_PLAY)) begin
          guess_valid  <= 1'b1;
          guess_letter <= letter;
          if (already) begin
            repeat_pulse <= 1'b1;
          end else begin
            guessed     <= guessed_post;
            wrong_count <= wrong_post;
            hit_pulse   <= in_mask;
            miss_pulse  <= !in_mask;
            if (wrong_post == MaxWrong)          game_status <= GS_LOST;
            else if ((mask & ~guessed_post) == 0) game_status <= GS_WON;
          end
        end else if ((letter == LTR_ENTER) && (game_status != GS_PLAY)) begin
          guessed     <= 26'd0;
          wrong_count <= 4'd0;
          game_status <= GS_PLAY;
          start_game  <= 1'b1;
        end
`ifdef GUESS_FILTER_ABORT_EN
        else if ((key_code == SC_ESC) && (game_status == GS_PLAY)) begin
          game_status <= GS_LOST;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_guess_filter.sv
// Self-checking bench for guess_filter: directed literal checks plus randomized
// byte streams compared every cycle against a behavioural game model.
module tb_guess_filter;

  localparam int MaxWrong = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic [25:0] mask = 26'd0;
  logic        guess_valid, hit_pulse, miss_pulse, repeat_pulse, start_game;
  logic [4:0]  guess_letter;
  logic [25:0] guessed;
  logic [3:0]  wrong_count;
  logic [1:0]  game_status;

  guess_filter #(.MAX_WRONG(MaxWrong), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .mask         (mask),
    .guess_valid  (guess_valid),
    .guess_letter (guess_letter),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .repeat_pulse (repeat_pulse),
    .start_game   (start_game),
    .guessed      (guessed),
    .wrong_count  (wrong_count),
    .game_status  (game_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int gv_count = 0;
  int start_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] m_pfx[$];
  logic [7:0] m_held;
  bit [25:0]  m_guessed;
  int         m_wrong, m_status, e_letter;
  bit         e_gv, e_hit, e_miss, e_rep, e_start;

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_pfx.delete();
    m_held = 8'h00; m_guessed = '0; m_wrong = 0; m_status = 0; e_letter = 0;
    e_gv = 0; e_hit = 0; e_miss = 0; e_rep = 0; e_start = 0;
  endfunction

  function automatic void press(input logic [7:0] b);
    int l = lookup(b);
    if (l >= 0 && m_status == 1) begin
      e_gv = 1; e_letter = l;
      if (m_guessed[l]) e_rep = 1;
      else begin
        m_guessed[l] = 1'b1;
        if (mask[l]) e_hit = 1;
        else begin
          e_miss = 1;
          if (m_wrong < MaxWrong) m_wrong++;
        end
        if (m_wrong == MaxWrong) m_status = 3;
        else if ((mask & ~m_guessed) == 26'd0) m_status = 2;
      end
    end else if (b == 8'h5A && m_status != 1) begin
      m_guessed = '0; m_wrong = 0; m_status = 1; e_start = 1;
    end
`ifdef GUESS_FILTER_ABORT_EN
    else if (b == 8'h76 && m_status == 1) m_status = 3;
`endif
  endfunction

  function automatic void model_step();
    logic [7:0] b;
    bit is_make, is_break;
    e_gv = 0; e_hit = 0; e_miss = 0; e_rep = 0; e_start = 0;
    if (!key_valid) return;
    b = key_code; is_make = 0; is_break = 0;
    if (m_pfx.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) m_pfx.push_back(b);
      else is_make = 1;
    end else if (m_pfx.size() == 1 && m_pfx[0] == 8'hE0) begin
      if (b == 8'hF0) m_pfx.push_back(b);
      else m_pfx.delete();
    end else if (m_pfx.size() == 1) begin
      is_break = 1; m_pfx.delete();
    end else begin
      m_pfx.delete();
    end
    if (is_break && b == m_held) m_held = 8'h00;
    if (is_make && b != m_held) begin
      m_held = b;
      press(b);
    end
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    check("guess_valid", 32'(guess_valid), 32'(e_gv));
    check("guess_letter", 32'(guess_letter), 32'(e_letter));
    check("hit_pulse", 32'(hit_pulse), 32'(e_hit));
    check("miss_pulse", 32'(miss_pulse), 32'(e_miss));
    check("repeat_pulse", 32'(repeat_pulse), 32'(e_rep));
    check("start_game", 32'(start_game), 32'(e_start));
    check("guessed", 32'(guessed), 32'(m_guessed));
    check("wrong_count", 32'(wrong_count), 32'(m_wrong));
    check("game_status", 32'(game_status), 32'(m_status));
    if (guess_valid) gv_count++;
    if (start_game) start_count++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    key_code = b; key_valid = 1'b1;
    @(posedge clk); #2;
    key_valid = 1'b0;
  endtask

  task automatic tap(input logic [7:0] b);
    send(b); send(8'hF0); send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1;
  endtask

  initial begin
    int gv0, st0, last, r;
    last = 0;
    idle(2);
    resetn = 1'b1;
    idle(1);
    check("rst_status", 32'(game_status), 0);
    check("rst_guessed", 32'(guessed), 0);
    check("rst_wrong", 32'(wrong_count), 0);

    // Single hit on A
    mask = 26'h7;
    send(8'h5A);
    check("enter_start", 32'(start_game), 1);
    check("enter_play", 32'(game_status), 1);
    send(8'hF0); send(8'h5A);
    gv0 = gv_count;
    send(8'h1C);
    check("a_gv", 32'(guess_valid), 1);
    check("a_hit", 32'(hit_pulse), 1);
    check("a_letter", 32'(guess_letter), 0);
    check("a_guessed", 32'(guessed), 1);
    check("a_wrong", 32'(wrong_count), 0);

    // Typematic suppression, then a real repeat
    send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
    check("rep_pulse", 32'(repeat_pulse), 1);
    check("rep_wrong", 32'(wrong_count), 0);
    idle(1);
    check("typematic_gv_count", 32'(gv_count - gv0), 2);
    send(8'hF0); send(8'h1C);

    // Lose: Z repeatedly (one miss), then D..H
    for (int i = 0; i < 6; i++) tap(8'h1A);
    check("z_wrong", 32'(wrong_count), 1);
    tap(8'h23); tap(8'h24); tap(8'h2B); tap(8'h34);
    send(8'h33);
    check("lost_miss", 32'(miss_pulse), 1);
    check("lost_status", 32'(game_status), 3);
    check("lost_wrong", 32'(wrong_count), 6);
    send(8'hF0); send(8'h33);
    gv0 = gv_count;
    tap(8'h43);
    idle(1);
    check("lost_ignored", 32'(gv_count - gv0), 0);

    // Win on A, B
    mask = 26'h3;
    tap(8'h5A);
    check("new_game_guessed", 32'(guessed), 0);
    tap(8'h1C);
    check("win_mid_status", 32'(game_status), 1);
    send(8'h32);
    check("win_hit", 32'(hit_pulse), 1);
    check("win_status", 32'(game_status), 2);
    send(8'hF0); send(8'h32);

    // Keypad Enter must not start
    st0 = start_count;
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    idle(1);
    check("kp_enter_no_start", 32'(start_count - st0), 0);
    send(8'h5A);
    check("enter_after_won", 32'(start_game), 1);
    check("enter_clears", 32'(guessed), 0);
    send(8'hF0); send(8'h5A);

    // Reset after a lone break prefix
    send(8'hF0);
    pulse_reset();
    send(8'h1C);
    check("post_rst_idle", 32'(game_status), 0);
    check("post_rst_gv", 32'(guess_valid), 0);
    tap(8'h5A);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
    check("post_rst_hit", 32'(hit_pulse), 1);
    send(8'hF0); send(8'h1C);
    send(8'h76);
`ifdef GUESS_FILTER_ABORT_EN
    check("esc_abort", 32'(game_status), 3);
`else
    check("esc_ignored", 32'(game_status), 1);
`endif
    send(8'hF0); send(8'h76);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (m_status != 1 && $urandom_range(0, 3) == 0) begin
        mask = 26'd0;
        for (int k = 0; k < 3; k++) mask[$urandom_range(0, 25)] = 1'b1;
      end
      if (r < 35) begin
        last = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : $urandom_range(0, 7);
        send(codes[last]);
      end else if (r < 60) begin
        send(8'hF0); send(codes[last]);
      end else if (r < 68) begin
        send(8'h5A);
        if ($urandom_range(0, 1) == 1) begin send(8'hF0); send(8'h5A); end
      end else if (r < 74) begin
        send(8'hE0);
        if ($urandom_range(0, 1) == 1) send(8'hF0);
        send(8'($urandom_range(0, 255)));
      end else if (r < 78) begin
        send(8'($urandom_range(0, 255)));
      end else if (r < 80) begin
        send(8'h76);
      end else if (r < 81) begin
        pulse_reset();
      end else begin
        idle($urandom_range(1, 2));
      end
    end
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
